// File: rtl/key_filter.sv
// key_filter: push-button front end. Two-flop synchroniser, debounce FSM and
// single-cycle event pulses (press, release, long-press, auto-repeat), plus a
// registered count-enable strobe (key_step) for the display pulse counter.
`timescale 1ns/1ps

module key_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic signal,
  output logic key_level,
  output logic key,
  output logic key_release,
  output logic long_press,
  output logic key_repeat,
  output logic key_step
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int RPT_W  = $clog2(REPEAT_CYCLES);

  // Terminal counts: every counter is cleared on entry, so it never passes these.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [RPT_W-1:0]  RPT_ONE   = RPT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HELD     = 3'd3,
    ST_REL_DB   = 3'd4
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              from_held_q;   // REL_DB was entered from HELD (else PRESSED)
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [RPT_W-1:0]  rpt_cnt_q;
  logic              key_level_q;
  logic              key_q;
  logic              key_release_q;
  logic              long_press_q;
  logic              key_repeat_q;
  logic              key_step_q;

  logic              s;

  assign s = sync2_q;

  // Synchroniser, debounce/hold FSM, counters and registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      from_held_q   <= 1'b0;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      rpt_cnt_q     <= '0;
      key_level_q   <= 1'b0;
      key_q         <= 1'b0;
      key_release_q <= 1'b0;
      long_press_q  <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_step_q    <= 1'b0;
    end else begin
      sync1_q       <= signal;
      sync2_q       <= sync1_q;

      // Pulses default low; each branch raises at most one event.
      key_q         <= 1'b0;
      key_release_q <= 1'b0;
      long_press_q  <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_step_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_q  <= ST_PRESS_DB;
            db_cnt_q <= '0;
          end
        end

        ST_PRESS_DB: begin
          if (!s) begin
            state_q <= ST_IDLE;   // bounce: no visible change
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= ST_PRESSED;
            key_q       <= 1'b1;
            key_step_q  <= 1'b1;
            key_level_q <= 1'b1;
            hold_cnt_q  <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
          end
        end

        ST_PRESSED: begin
          // Release is checked first so it beats a coincident long terminal count.
          if (!s) begin
            state_q     <= ST_REL_DB;
            db_cnt_q    <= '0;
            from_held_q <= 1'b0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= ST_HELD;
            long_press_q <= 1'b1;
            rpt_cnt_q    <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
          end
        end

        ST_HELD: begin
          // Release is checked first so it beats a coincident repeat terminal count.
          if (!s) begin
            state_q     <= ST_REL_DB;
            db_cnt_q    <= '0;
            from_held_q <= 1'b1;
          end else if (rpt_cnt_q == RPT_LAST) begin
            key_repeat_q <= 1'b1;
            key_step_q   <= 1'b1;
            rpt_cnt_q    <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_ONE;
          end
        end

        ST_REL_DB: begin
          if (s) begin
            // Release bounce: resume where we were, hold/repeat counters frozen.
            state_q <= from_held_q ? ST_HELD : ST_PRESSED;
          end else if (db_cnt_q == DB_LAST) begin
            state_q       <= ST_IDLE;
            key_release_q <= 1'b1;
            key_level_q   <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          key_level_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_level   = key_level_q;
  assign key         = key_q;
  assign key_release = key_release_q;
  assign long_press  = long_press_q;
  assign key_repeat  = key_repeat_q;
  assign key_step    = key_step_q;

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: each scenario pushes the cycle-stamped
// events it expects; a negedge monitor compares all pulses and the level
// every cycle against the scoreboard head (no event => all pulses low).
`timescale 1ns/1ps

module tb_key_filter;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  // Pulse vector layout: {key_step, key_repeat, long_press, key_release, key}
  localparam logic [31:0] M_KEY  = 32'h0000_0011;
  localparam logic [31:0] M_REL  = 32'h0000_0002;
  localparam logic [31:0] M_LONG = 32'h0000_0004;
  localparam logic [31:0] M_RPT  = 32'h0000_0018;

  typedef struct {
    int          cyc;
    logic [31:0] mask;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic signal;
  logic key_level, key, key_release, long_press, key_repeat, key_step;

  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic rst_smp  = 1'b1;
  logic exp_level = 1'b0;
  logic [31:0] mon_act;
  logic [31:0] mon_exp;
  ev_t  sb_q[$];

  key_filter #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal     (signal),
    .key_level  (key_level),
    .key        (key),
    .key_release(key_release),
    .long_press (long_press),
    .key_repeat (key_repeat),
    .key_step   (key_step)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  // Remember whether the bench drove reset at the latest edge.
  always @(posedge clk) rst_smp <= rst;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Insert an expected event keeping the scoreboard ordered by cycle.
  task automatic push_ev(input int c, input logic [31:0] m);
    ev_t e;
    int  i;
    e.cyc  = c;
    e.mask = m;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
    sb_q.insert(i, e);
  endtask

  // Drive one sample; returns 1 ns after the edge that sampled it.
  task automatic step(input logic v);
    signal = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) step(v);
  endtask

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      check_eq("sb_stale", sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    mon_exp = 32'h0;
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_exp = sb_q[0].mask;
      void'(sb_q.pop_front());
    end
    mon_act = {27'd0, key_step, key_repeat, long_press, key_release, key};
    check_eq("pulses", mon_act, mon_exp);
    if (rst_smp)         exp_level = 1'b0;
    else if (mon_exp[0]) exp_level = 1'b1;
    else if (mon_exp[1]) exp_level = 1'b0;
    else                 exp_level = exp_level;
    check_eq("key_level", {31'd0, key_level}, {31'd0, exp_level});
  end

  initial begin
    int e0;
    int k;
    int f0;
    int r;
    logic bounce [7];

    rst    = 1'b1;
    signal = 1'b0;
    hold(1'b0, 3);
    rst = 1'b0;
    check_eq("reset_outs", {26'd0, key_level, key_step, key_repeat, long_press, key_release, key}, 32'h0);

    // Clean press sampled at edge 10: key after edge 16, then short hold and release.
    while (cyc < 9) step(1'b0);
    step(1'b1);
    e0 = cyc;
    check_eq("press_edge", e0, 10);
    push_ev(e0 + D + 2, M_KEY);
    hold(1'b1, D + 2 + 10);
    step(1'b0);
    f0 = cyc;
    push_ev(f0 + D + 2, M_REL);
    hold(1'b0, D + 5);

    // Bounce on press, then long hold with auto-repeat and clean release.
    bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    foreach (bounce[i]) step(bounce[i]);
    step(1'b1);
    k = cyc + D + 2;
    push_ev(k, M_KEY);
    push_ev(k + L, M_LONG);
    for (int i = 1; i <= 5; i++) push_ev(k + L + i * R, M_RPT);
    while (cyc < k + 45) step(1'b1);
    step(1'b0);                       // s low reaches the FSM at k+48, before k+50
    f0 = cyc;
    push_ev(f0 + D + 2, M_REL);
    hold(1'b0, D + 5);

    // Two-sample release glitch while HELD. The FSM loses three increments:
    // the HELD->REL_DB edge, one REL_DB cycle and the REL_DB->HELD edge.
    step(1'b1);
    k = cyc + D + 2;
    push_ev(k, M_KEY);
    push_ev(k + L, M_LONG);
    push_ev(k + L + R, M_RPT);
    push_ev(k + L + 2 * R, M_RPT);
    push_ev(k + L + 3 * R + 3, M_RPT);
    push_ev(k + L + 4 * R + 3, M_RPT);
    while (cyc < k + L + 2 * R) step(1'b1);
    hold(1'b0, 2);
    while (cyc < k + L + 4 * R + 3) step(1'b1);
    step(1'b0);                       // s low at k+46, before the k+48 repeat
    f0 = cyc;
    push_ev(f0 + D + 2, M_REL);
    hold(1'b0, D + 5);

    // One-cycle reset in PRESSED with the button still down: fresh press.
    step(1'b1);
    k = cyc + D + 2;
    push_ev(k, M_KEY);
    while (cyc < k + 5) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    r = cyc;
    rst = 1'b0;
    check_eq("midhold_rst_outs", {26'd0, key_level, key_step, key_repeat, long_press, key_release, key}, 32'h0);
    step(1'b1);                       // first post-reset edge sampling high
    k = r + 1 + D + 2;
    push_ev(k, M_KEY);
    push_ev(k + L, M_LONG);
    while (cyc < k + L) step(1'b1);
    step(1'b0);                       // s low at k+L+3, before first repeat
    f0 = cyc;
    push_ev(f0 + D + 2, M_REL);
    hold(1'b0, D + 5);

    // Release reaching the FSM exactly on the long terminal count: no long_press.
    step(1'b1);
    k = cyc + D + 2;
    push_ev(k, M_KEY);
    while (cyc < k + L - 3) step(1'b1);
    step(1'b0);
    f0 = cyc;
    push_ev(f0 + D + 2, M_REL);
    hold(1'b0, D + 8);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
